// File: rtl/uart_rx_core_if.sv
// Byte delivery channel between the UART receiver and its consumer.
//
// Handshake: the producer raises rx_valid when rx_data holds a byte and keeps
// rx_data stable until the transfer. A transfer happens on every rising clk
// edge where rx_valid & rx_ready are both 1. rx_ready may be asserted at any
// time. It is ignored while rx_valid is 0.
interface uart_rx_core_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  // Receiver side: owns the holding register
  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  // Consumer side
  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver, LSB first, fixed baud.
// rx is synchronised and then sampled at mid-bit by a half-bit start check
// followed by full-bit strides. Completed bytes go into a one-entry
// valid/ready holding register. Framing and overrun errors are reported
// as single-cycle pulses.
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx,
  uart_rx_core_if.master        rx_if,
  output logic                  frame_err,
  output logic                  overrun_err,
  output logic                  busy,
  output logic [2:0]            dbg_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rxs;

  state_t                 r_state;
  logic [CW-1:0]          r_baud;
  logic [2:0]             r_idx;
  logic [7:0]             r_shift;
  logic                   r_busy;
  logic                   r_frame_err;
  logic                   r_done;
  logic                   w_tick;

  logic [7:0]             r_data;
  logic                   r_valid;
  logic                   r_overrun;

  // Synchroniser chain; loads idle level so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
    end
  end

  assign w_rxs = r_sync[SYNC_STAGES-1];

  // START waits half a bit to land mid-bit; later states stride a full bit
  assign w_tick = (r_state == S_START) ? (r_baud == HALF_M1) : (r_baud == FULL_M1);

  // Receive FSM with baud counter, bit index, shift register and status pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_baud      <= '0;
      r_idx       <= '0;
      r_shift     <= 8'h00;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_done      <= 1'b0;

      if ((r_state == S_IDLE) || w_tick) begin
        r_baud <= '0;
      end else begin
        r_baud <= r_baud + CW'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (!w_rxs) begin
            r_state <= S_START;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (!w_rxs) begin
              r_state <= S_DATA;
              r_idx   <= '0;
            end else begin
              // Line went back high before mid-start: treat as noise
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_shift[r_idx] <= w_rxs;
            if (r_idx == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end
        end
        S_STOP: begin
          if (w_tick) begin
            if (w_rxs) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_WAIT_IDLE;
            end
          end
        end
        S_WAIT_IDLE: begin
          // Hold off until the line idles so a break reports only once
          if (w_rxs) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // One-entry holding register; a completion in the same cycle as a consume refills it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_done) begin
        if (!r_valid || rx_if.rx_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && rx_if.rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_if.rx_data  = r_data;
  assign rx_if.rx_valid = r_valid;
  assign frame_err      = r_frame_err;
  assign overrun_err    = r_overrun;
  assign busy           = r_busy;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at 16 clocks per bit.
module tb_uart_rx_core;

  localparam int CPB = 16;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       frame_err;
  logic       overrun_err;
  logic       busy;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  uart_rx_core_if ifc ();

  uart_rx_core #(
    .CLKS_PER_BIT (CPB),
    .SYNC_STAGES  (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .rx_if       (ifc),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- monitor ----------------
  int         n_valid_cyc = 0;
  int         n_ferr_cyc  = 0;
  int         n_ovr_cyc   = 0;
  int         n_xfer      = 0;
  logic [7:0] got_data [64];

  always @(negedge clk) begin
    if (ifc.rx_valid === 1'b1 && ifc.rx_ready === 1'b1 && n_xfer < 64) begin
      got_data[n_xfer] = ifc.rx_data;
      n_xfer = n_xfer + 1;
    end
    if (ifc.rx_valid === 1'b1) n_valid_cyc = n_valid_cyc + 1;
    if (frame_err === 1'b1)    n_ferr_cyc  = n_ferr_cyc + 1;
    if (overrun_err === 1'b1)  n_ovr_cyc   = n_ovr_cyc + 1;
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q [$];
  int         rd_idx = 0;

  task automatic sb_drain(input string name);
    logic [7:0] e;
    while (rd_idx < n_xfer) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL %s sb: unexpected byte %02h, none expected", name, got_data[rd_idx]);
      end else begin
        e = exp_q.pop_front();
        if (got_data[rd_idx] !== e) begin
          n_errors++;
          $display("FAIL %s sb: got %02h expected %02h", name, got_data[rd_idx], e);
        end
      end
      rd_idx++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s sb: %0d expected bytes never delivered, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- snapshots of monitor counters ----------------
  int b_valid, b_ferr, b_ovr;

  task automatic snap();
    b_valid = n_valid_cyc;
    b_ferr  = n_ferr_cyc;
    b_ovr   = n_ovr_cyc;
  endtask

  // ---------------- drivers ----------------
  // All drivers start and end 1 time unit after a rising edge.
  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_ready();
    ifc.rx_ready = 1'b1;
    @(posedge clk);
    #1;
    ifc.rx_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    ifc.rx_ready = 1'b1;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (ifc.rx_data !== 8'h00) begin n_errors++; $display("FAIL reset rx_data: got %02h expected 00", ifc.rx_data); end
    n_checks++; if (ifc.rx_valid !== 1'b0) begin n_errors++; $display("FAIL reset rx_valid: got %b expected 0", ifc.rx_valid); end
    n_checks++; if (frame_err !== 1'b0) begin n_errors++; $display("FAIL reset frame_err: got %b expected 0", frame_err); end
    n_checks++; if (overrun_err !== 1'b0) begin n_errors++; $display("FAIL reset overrun_err: got %b expected 0", overrun_err); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset busy: got %b expected 0", busy); end
    n_checks++; if (dbg_state !== 3'd0) begin n_errors++; $display("FAIL reset state: got %0d expected 0", dbg_state); end
    rst_n = 1'b1;
    idle(4);
  endtask

  task automatic test_single_byte();
    snap();
    exp_q.push_back(8'hA5);
    drive_bit(1'b0);
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL single busy_mid: got %b expected 1", busy); end
    for (int i = 0; i < 8; i++) drive_bit(rx_bit(8'hA5, i));
    drive_bit(1'b1);
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL single busy_end: got %b expected 0", busy); end
    idle(8);
    n_checks++; if (n_valid_cyc - b_valid !== 1) begin n_errors++; $display("FAIL single valid_cycles: got %0d expected 1", n_valid_cyc - b_valid); end
    n_checks++; if (n_ferr_cyc - b_ferr !== 0) begin n_errors++; $display("FAIL single frame_err: got %0d expected 0", n_ferr_cyc - b_ferr); end
    n_checks++; if (n_ovr_cyc - b_ovr !== 0) begin n_errors++; $display("FAIL single overrun: got %0d expected 0", n_ovr_cyc - b_ovr); end
    n_checks++; if (ifc.rx_data !== 8'hA5) begin n_errors++; $display("FAIL single rx_data: got %02h expected a5", ifc.rx_data); end
    sb_drain("single");
  endtask

  function automatic logic rx_bit(input logic [7:0] b, input int i);
    return b[i];
  endfunction

  task automatic test_glitch();
    snap();
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    n_checks++; if (dbg_state !== 3'd1) begin n_errors++; $display("FAIL glitch start_seen: got %0d expected 1", dbg_state); end
    repeat (20) @(posedge clk);
    #1;
    n_checks++; if (dbg_state !== 3'd0) begin n_errors++; $display("FAIL glitch state: got %0d expected 0", dbg_state); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL glitch busy: got %b expected 0", busy); end
    n_checks++; if (n_valid_cyc - b_valid !== 0) begin n_errors++; $display("FAIL glitch valid: got %0d expected 0", n_valid_cyc - b_valid); end
    n_checks++; if (n_ferr_cyc - b_ferr !== 0) begin n_errors++; $display("FAIL glitch frame_err: got %0d expected 0", n_ferr_cyc - b_ferr); end
  endtask

  task automatic test_frame_error();
    snap();
    send_frame(8'h3C, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    n_checks++; if (dbg_state !== 3'd4) begin n_errors++; $display("FAIL ferr wait_state: got %0d expected 4", dbg_state); end
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL ferr wait_busy: got %b expected 1", busy); end
    idle(20);
    n_checks++; if (dbg_state !== 3'd0) begin n_errors++; $display("FAIL ferr idle_state: got %0d expected 0", dbg_state); end
    n_checks++; if (n_ferr_cyc - b_ferr !== 1) begin n_errors++; $display("FAIL ferr pulses: got %0d expected 1", n_ferr_cyc - b_ferr); end
    n_checks++; if (n_valid_cyc - b_valid !== 0) begin n_errors++; $display("FAIL ferr valid: got %0d expected 0", n_valid_cyc - b_valid); end
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    idle(8);
    n_checks++; if (n_valid_cyc - b_valid !== 1) begin n_errors++; $display("FAIL ferr next_valid: got %0d expected 1", n_valid_cyc - b_valid); end
    n_checks++; if (n_ferr_cyc - b_ferr !== 1) begin n_errors++; $display("FAIL ferr next_ferr: got %0d expected 1", n_ferr_cyc - b_ferr); end
    sb_drain("ferr");
  endtask

  task automatic test_overrun();
    ifc.rx_ready = 1'b0;
    snap();
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(8);
    n_checks++; if (ifc.rx_valid !== 1'b1) begin n_errors++; $display("FAIL ovr valid: got %b expected 1", ifc.rx_valid); end
    n_checks++; if (ifc.rx_data !== 8'h11) begin n_errors++; $display("FAIL ovr rx_data: got %02h expected 11", ifc.rx_data); end
    n_checks++; if (n_ovr_cyc - b_ovr !== 1) begin n_errors++; $display("FAIL ovr pulses: got %0d expected 1", n_ovr_cyc - b_ovr); end
    pulse_ready();
    n_checks++; if (ifc.rx_valid !== 1'b0) begin n_errors++; $display("FAIL ovr cleared: got %b expected 0", ifc.rx_valid); end
    sb_drain("ovr");
  endtask

  task automatic test_back_to_back();
    ifc.rx_ready = 1'b0;
    snap();
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    send_frame(8'h55, 1'b1);
    idle(4);
    n_checks++; if (ifc.rx_data !== 8'h55) begin n_errors++; $display("FAIL simul hold: got %02h expected 55", ifc.rx_data); end
    // Stop sample lands on the 155th edge of the frame; the holding
    // register acts on the next edge, so rx_ready is up for exactly that edge.
    fork
      send_frame(8'hAA, 1'b1);
      begin
        repeat (155) @(posedge clk);
        #1;
        ifc.rx_ready = 1'b1;
        @(posedge clk);
        #1;
        ifc.rx_ready = 1'b0;
      end
    join
    idle(8);
    n_checks++; if (n_ovr_cyc - b_ovr !== 0) begin n_errors++; $display("FAIL simul overrun: got %0d expected 0", n_ovr_cyc - b_ovr); end
    n_checks++; if (ifc.rx_data !== 8'hAA) begin n_errors++; $display("FAIL simul rx_data: got %02h expected aa", ifc.rx_data); end
    n_checks++; if (ifc.rx_valid !== 1'b1) begin n_errors++; $display("FAIL simul valid: got %b expected 1", ifc.rx_valid); end
    pulse_ready();
    sb_drain("simul");
  endtask

  task automatic test_reset_mid_frame();
    ifc.rx_ready = 1'b1;
    snap();
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(rx_bit(8'hF0, i));
    rx = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    n_checks++; if (dbg_state !== 3'd2) begin n_errors++; $display("FAIL rstmid in_data: got %0d expected 2", dbg_state); end
    rst_n = 1'b0;
    rx = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_checks++; if (dbg_state !== 3'd0) begin n_errors++; $display("FAIL rstmid state: got %0d expected 0", dbg_state); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rstmid busy: got %b expected 0", busy); end
    n_checks++; if (ifc.rx_data !== 8'h00) begin n_errors++; $display("FAIL rstmid rx_data: got %02h expected 00", ifc.rx_data); end
    n_checks++; if (ifc.rx_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid valid: got %b expected 0", ifc.rx_valid); end
    idle(40);
    n_checks++; if (n_valid_cyc - b_valid !== 0) begin n_errors++; $display("FAIL rstmid no_byte: got %0d expected 0", n_valid_cyc - b_valid); end
    n_checks++; if ((n_ferr_cyc - b_ferr) + (n_ovr_cyc - b_ovr) !== 0) begin n_errors++; $display("FAIL rstmid no_err: got %0d expected 0", (n_ferr_cyc - b_ferr) + (n_ovr_cyc - b_ovr)); end
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1);
    idle(8);
    n_checks++; if (ifc.rx_data !== 8'h0F) begin n_errors++; $display("FAIL rstmid next: got %02h expected 0f", ifc.rx_data); end
    sb_drain("rstmid");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    ifc.rx_ready = 1'b1;
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- 8N1 UART receiver, LSB first, fixed baud set by parameter; the receive-side counterpart of the design's UART transmitter.
- Sits between the asynchronous `rx` pad input and on-chip consumers.
- Delivers bytes through a one-entry valid/ready holding register.
- Reports framing and overrun errors as single-cycle pulses.

Parameters:
- CLKS_PER_BIT, 5208, clk cycles per bit (50 MHz / 9600 baud); legal range >= 4.
- SYNC_STAGES, 2, flip-flop stages on `rx` before use; legal range >= 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- rx  input  1  asynchronous serial line; idles high.
- rx_data  output  8  received byte; stable while rx_valid=1.
- rx_valid  output  1  holding register full.
- rx_ready  input  1  consumer accepts; transfer occurs when rx_valid & rx_ready on a clk edge.
- frame_err  output  1  1-cycle pulse: stop bit sampled 0.
- overrun_err  output  1  1-cycle pulse: completed byte dropped because the holding register was full.
- busy  output  1  1 whenever FSM is not IDLE.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FSM goes to IDLE; bit counter and baud counter clear to 0.
  - Shift register clears to 0x00.
  - rx_data=0x00; rx_valid=0; frame_err=0; overrun_err=0; busy=0.
  - Synchronizer flops load 1.
  - Reset mid-frame abandons the frame with no error pulse.
- Synchronizer: `rxs` is `rx` after SYNC_STAGES flops. Only `rxs` is used internally.
- Baud counter: counts 0..limit-1, then signals a tick and restarts at 0.
- IDLE:
  - rxs=0 moves to START with baud counter 0.
- START:
  - Waits CLKS_PER_BIT/2 cycles (integer division).
  - If rxs=0, goes to DATA, clears baud counter and bit index.
  - If rxs=1, treats it as a glitch and returns to IDLE; no pulse.
- DATA:
  - Every CLKS_PER_BIT cycles, samples rxs into shift register bit[idx], idx from 0 to 7 (LSB first).
  - After the 8th sample, goes to STOP.
- STOP:
  - After CLKS_PER_BIT cycles, samples rxs.
  - If 1: completes the byte and goes to IDLE.
  - If 0: frame_err=1 for exactly one cycle, byte discarded, goes to WAIT_IDLE.
- WAIT_IDLE:
  - Stays until rxs=1, then goes to IDLE. A break condition therefore produces exactly one frame_err.
- Completion latency: rx_valid rises on the clk edge after the stop-bit sample edge.
- Holding register, on the byte-completion cycle:
  - rx_valid=0: rx_data<=byte, rx_valid<=1.
  - rx_valid=1 and rx_ready=1 in the same cycle: old byte transferred, rx_data<=new byte, rx_valid stays 1, no overrun.
  - rx_valid=1 and rx_ready=0: new byte dropped, rx_data unchanged, overrun_err=1 for one cycle.
- Holding register, otherwise: rx_valid & rx_ready clears rx_valid on that edge.
- rx_ready is ignored while rx_valid=0.
- The receiver never stalls: the next start bit is accepted from IDLE regardless of rx_valid.
- Back-to-back frames: a falling edge seen on the first cycle after STOP→IDLE is detected. No dead time beyond that one cycle.

Test Plan (CLKS_PER_BIT=16, SYNC_STAGES=2, rx_ready=1 unless stated):
- Single byte: drive frame for 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1).
  - rx_valid pulses 1 cycle with rx_data=0xA5.
  - frame_err=0, overrun_err=0.
  - busy high from 2 cycles after the falling edge until the stop sample.
- Glitch rejection: rx low for 4 cycles, then high.
  - FSM returns to IDLE; no rx_valid, no frame_err.
- Framing error: 0x3C frame with stop bit 0, then line held low 40 cycles, then high.
  - Exactly one frame_err pulse, rx_valid stays 0.
  - Following 0x81 frame is received correctly.
- Overrun: rx_ready=0; send 0x11 then 0x22 back-to-back.
  - rx_data=0x11, rx_valid=1, one overrun_err pulse at 0x22 completion.
  - Raising rx_ready for 1 cycle clears rx_valid.
- Simultaneous consume/complete: hold 0x55 with rx_ready=0, then pulse rx_ready=1 on the exact completion cycle of 0xAA.
  - No overrun; rx_data=0xAA, rx_valid=1.
- Reset mid-frame: assert rst_n=0 for 1 cycle during DATA bit 3 of a 0xF0 frame.
  - All outputs return to reset values; no byte or error emitted.
  - Subsequent clean 0x0F frame received as 0x0F.
